// File: rtl/qq_pkg.sv
// Shared types and constants for the quickQueue command scheduler.
package qq_pkg;

  localparam int unsigned QQ_KEY_W = 32;

  typedef logic [QQ_KEY_W-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE,
    ENQ,
    DEQ,
    GAP
  } sched_state_t;

  localparam logic [3:0] PEND_MAX = 4'd15;

endpackage

// File: rtl/qq_key_fifo.sv
// Show-ahead synchronous key FIFO; pointers carry an extra wrap bit for full/empty.
module qq_key_fifo #(
  parameter int unsigned KEY_W      = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [KEY_W-1:0] din,
  output logic [KEY_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [KEY_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/qq_cmd_sched.sv
// Command scheduler upstream of quickQueueTop: serialises enq/deq level pulses.
// Optional QQ_SCHED_STATS_EN adds issued-enqueue/dequeue and drop counters.
module qq_cmd_sched #(
  parameter int unsigned KEY_W      = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ENQ_HOLD   = 20,
  parameter int unsigned DEQ_HOLD   = 10,
  parameter int unsigned GAP        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key,
  input  logic             deq_req,
  input  logic [31:0]      array_size,
  output logic             core_enq,
  output logic             core_deq,
  output logic [KEY_W-1:0] core_key,
  output logic [31:0]      occupancy,
  output logic             q_full,
  output logic             q_empty,
  output logic             deq_drop
`ifdef QQ_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_enq,
  output logic [31:0]      stat_deq,
  output logic [15:0]      stat_drop
`endif
);

  import qq_pkg::sched_state_t;
  import qq_pkg::IDLE;
  import qq_pkg::ENQ;
  import qq_pkg::DEQ;
  import qq_pkg::PEND_MAX;

  localparam logic [7:0] ENQ_LAST = 8'(ENQ_HOLD - 1);
  localparam logic [7:0] DEQ_LAST = 8'(DEQ_HOLD - 1);
  localparam logic [7:0] GAP_LAST = (GAP > 1) ? 8'(GAP - 2) : 8'd0;

  sched_state_t     state;
  sched_state_t     state_nxt;
  logic [7:0]       hold_cnt;
  logic [7:0]       hold_nxt;
  logic             start_enq;
  logic             start_deq;
  logic [3:0]       pend_deq;
  logic             drop_now;
  logic             req_accept;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [KEY_W-1:0] fifo_dout;

  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && !fifo_full;
  assign q_full     = (occupancy >= array_size);
  assign q_empty    = (occupancy == '0);
  assign core_enq   = (state == ENQ);
  assign core_deq   = (state == DEQ);
  assign drop_now   = deq_req && (pend_deq == PEND_MAX);
  assign req_accept = deq_req && !drop_now;

  qq_key_fifo #(
    .KEY_W      (KEY_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_key_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (start_enq),
    .din   (in_key),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The IDLE decision cycle is itself one of the GAP quiet cycles, so the GAP
  // state only lasts GAP-1 cycles and is skipped entirely when GAP==1.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    start_enq = 1'b0;
    start_deq = 1'b0;
    case (state)
      IDLE: begin
        if ((pend_deq != '0) && !q_empty) begin
          state_nxt = DEQ;
          hold_nxt  = '0;
          start_deq = 1'b1;
        end else if (!fifo_empty && !q_full) begin
          state_nxt = ENQ;
          hold_nxt  = '0;
          start_enq = 1'b1;
        end
      end
      ENQ: begin
        if (hold_cnt == ENQ_LAST) begin
          state_nxt = (GAP > 1) ? qq_pkg::GAP : IDLE;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      DEQ: begin
        if (hold_cnt == DEQ_LAST) begin
          state_nxt = (GAP > 1) ? qq_pkg::GAP : IDLE;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      qq_pkg::GAP: begin
        if (hold_cnt == GAP_LAST) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
      core_key  <= '0;
    end else begin
      if (start_enq) begin
        occupancy <= occupancy + 32'd1;
        core_key  <= fifo_dout;
      end else if (start_deq) begin
        occupancy <= occupancy - 32'd1;
      end
    end
  end

  // A same-cycle accepted request and dequeue issue cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_deq <= '0;
      deq_drop <= 1'b0;
    end else begin
      deq_drop <= drop_now;
      case ({req_accept, start_deq})
        2'b10:   pend_deq <= pend_deq + 4'd1;
        2'b01:   pend_deq <= pend_deq - 4'd1;
        default: pend_deq <= pend_deq;
      endcase
    end
  end

`ifdef QQ_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_enq  <= '0;
      stat_deq  <= '0;
      stat_drop <= '0;
    end else begin
      if (start_enq) begin
        stat_enq <= stat_enq + 32'd1;
      end
      if (start_deq) begin
        stat_deq <= stat_deq + 32'd1;
      end
      if (drop_now) begin
        stat_drop <= stat_drop + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_qq_cmd_sched.sv
// Randomized self-checking bench for qq_cmd_sched against a command-level reference model.
module tb_qq_cmd_sched;
  import qq_pkg::*;

  localparam int ENQ_HOLD_C = 20;
  localparam int DEQ_HOLD_C = 10;
  localparam int GAP_C      = 5;
  localparam int DEPTH_C    = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_key;
  logic        deq_req;
  logic [31:0] array_size;
  logic        core_enq;
  logic        core_deq;
  logic [31:0] core_key;
  logic [31:0] occupancy;
  logic        q_full;
  logic        q_empty;
  logic        deq_drop;
`ifdef QQ_SCHED_STATS_EN
  logic [31:0] stat_enq;
  logic [31:0] stat_deq;
  logic [15:0] stat_drop;
`endif

  qq_cmd_sched #(
    .KEY_W      (32),
    .FIFO_DEPTH (DEPTH_C),
    .ENQ_HOLD   (ENQ_HOLD_C),
    .DEQ_HOLD   (DEQ_HOLD_C),
    .GAP        (GAP_C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_key     (in_key),
    .deq_req    (deq_req),
    .array_size (array_size),
    .core_enq   (core_enq),
    .core_deq   (core_deq),
    .core_key   (core_key),
    .occupancy  (occupancy),
    .q_full     (q_full),
    .q_empty    (q_empty),
    .deq_drop   (deq_drop)
`ifdef QQ_SCHED_STATS_EN
    ,
    .stat_enq   (stat_enq),
    .stat_deq   (stat_deq),
    .stat_drop  (stat_drop)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a command is either running (kind 1=enq, 2=deq) for
  // HOLD+GAP-1 cycles or the scheduler is idle and decides at the next edge.
  key_t        m_fifo[$];
  key_t        tx_q[$];
  key_t        m_key;
  int unsigned m_occ;
  int unsigned asize;
  int          m_pend;
  int          m_kind;
  int          m_t;
  bit          m_drop;
  int unsigned m_nenq, m_ndeq, m_ndrop;
  bit          req;
  int          obs_enq_cyc, obs_deq_cyc, obs_drop;

  task automatic model_reset();
    m_fifo.delete();
    tx_q.delete();
    m_key  = '0;
    m_occ  = 0;
    m_pend = 0;
    m_kind = 0;
    m_t    = 0;
    m_drop = 1'b0;
    m_nenq = 0;
    m_ndeq = 0;
    m_ndrop = 0;
    req    = 1'b0;
  endtask

  task automatic step();
    bit acc, drop, exp_enq, exp_deq;
    int dec, len;
    in_valid = (tx_q.size() > 0);
    in_key   = in_valid ? tx_q[0] : '0;
    deq_req  = req;
    @(posedge clk);
    acc  = in_valid && (m_fifo.size() < DEPTH_C);
    drop = req && (m_pend == 15);
    dec  = 0;
    if (m_kind != 0) begin
      len = (m_kind == 1) ? (ENQ_HOLD_C + GAP_C - 1) : (DEQ_HOLD_C + GAP_C - 1);
      m_t++;
      if (m_t == len) m_kind = 0;
    end else if (m_pend > 0 && m_occ > 0) begin
      m_kind = 2; m_t = 0; m_occ--; dec = 1; m_ndeq++;
    end else if (m_fifo.size() > 0 && m_occ < asize) begin
      m_kind = 1; m_t = 0; m_key = m_fifo.pop_front(); m_occ++; m_nenq++;
    end
    if (acc) begin
      m_fifo.push_back(in_key);
      void'(tx_q.pop_front());
    end
    m_pend = m_pend + ((req && !drop) ? 1 : 0) - dec;
    m_drop = drop;
    if (drop) m_ndrop++;
    req = 1'b0;
    #1;
    exp_enq = (m_kind == 1) && (m_t < ENQ_HOLD_C);
    exp_deq = (m_kind == 2) && (m_t < DEQ_HOLD_C);
    if (core_enq) obs_enq_cyc++;
    if (core_deq) obs_deq_cyc++;
    if (deq_drop) obs_drop++;
    check("core_enq", 32'(core_enq), 32'(exp_enq));
    check("core_deq", 32'(core_deq), 32'(exp_deq));
    if (exp_enq) check("core_key", core_key, m_key);
    check("occupancy", occupancy, m_occ);
    check("q_full", 32'(q_full), 32'(m_occ >= asize));
    check("q_empty", 32'(q_empty), 32'(m_occ == 0));
    check("in_ready", 32'(in_ready), 32'(m_fifo.size() < DEPTH_C));
    check("deq_drop", 32'(deq_drop), 32'(m_drop));
`ifdef QQ_SCHED_STATS_EN
    check("stat_enq", stat_enq, m_nenq);
    check("stat_deq", stat_deq, m_ndeq);
    check("stat_drop", 32'(stat_drop), 32'(m_ndrop[15:0]));
`endif
  endtask

  task automatic do_reset(input logic [31:0] a);
    rst = 1'b1;
    in_valid = 1'b0;
    in_key = '0;
    deq_req = 1'b0;
    array_size = a;
    asize = a;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_enq", 32'(core_enq), 32'd0);
    check("rst_deq", 32'(core_deq), 32'd0);
    check("rst_occ", occupancy, 32'd0);
    check("rst_empty", 32'(q_empty), 32'd1);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_drop", 32'(deq_drop), 32'd0);
    check("rst_key", core_key, 32'd0);
  endtask

  initial begin
    int burst;
    rst = 1'b1;
    in_valid = 1'b0;
    in_key = '0;
    deq_req = 1'b0;
    array_size = 32'd3;

    // 1: dequeue request while empty stays pending
    do_reset(32'd3);
    req = 1'b1;
    step();
    repeat (10) step();
    check("t1_q_empty", 32'(q_empty), 32'd1);

    // 2: one key, then the pending dequeue
    obs_enq_cyc = 0; obs_deq_cyc = 0;
    tx_q.push_back(key_t'(4));
    repeat (60) step();
    check("t2_enq_cycles", 32'(obs_enq_cyc), 32'd20);
    check("t2_deq_cycles", 32'(obs_deq_cyc), 32'd10);

    // 3: fill the core
    tx_q.push_back(key_t'(2));
    tx_q.push_back(key_t'(9));
    tx_q.push_back(key_t'(3));
    repeat (100) step();
    check("t3_occ", occupancy, 32'd3);
    check("t3_full", 32'(q_full), 32'd1);

    // 4: keys pile up in the FIFO while full
    obs_enq_cyc = 0;
    tx_q.push_back(key_t'(7));
    for (int i = 0; i < 8; i++) tx_q.push_back(key_t'(100 + i));
    repeat (15) step();
    check("t4_ready", 32'(in_ready), 32'd0);
    check("t4_no_enq", 32'(obs_enq_cyc), 32'd0);

    // 5: saturate the pending counter
    obs_drop = 0;
    for (int i = 0; i < 17; i++) begin
      req = 1'b1;
      step();
    end
    repeat (600) step();
    check("t5_drops", 32'(obs_drop), 32'd1);

    // 6: asynchronous reset in the middle of an enqueue window
    tx_q.push_back(key_t'(55));
    begin
      int w = 0;
      while (!core_enq && w < 40) begin
        step();
        w++;
      end
    end
    check("t6_enq_seen", 32'(core_enq), 32'd1);
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    check("t6_enq_low", 32'(core_enq), 32'd0);
    check("t6_occ", occupancy, 32'd0);
    check("t6_empty", 32'(q_empty), 32'd1);
    check("t6_ready", 32'(in_ready), 32'd1);
`ifdef QQ_SCHED_STATS_EN
    check("t6_stat_enq", stat_enq, 32'd0);
    check("t6_stat_deq", stat_deq, 32'd0);
    check("t6_stat_drop", 32'(stat_drop), 32'd0);
`endif

    // Random traffic; round 0 uses array_size=0
    for (int r = 0; r < 5; r++) begin
      do_reset((r == 0) ? 32'd0 : 32'($urandom_range(1, 5)));
      obs_enq_cyc = 0;
      burst = 0;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 3) == 0 && tx_q.size() < 4) tx_q.push_back(key_t'($urandom));
        if (burst > 0) begin
          req = 1'b1;
          burst--;
        end else begin
          req = ($urandom_range(0, 9) == 0);
          if ($urandom_range(0, 199) == 0) burst = 20;
        end
        step();
      end
      if (r == 0) check("size0_no_enq", 32'(obs_enq_cyc), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
